pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 169 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer with staged domain reset release
module pll_lock_sequencer #(
   parameter int PLL_RST_CYCLES = 8,
   parameter int LOCK_TIMEOUT   = 1048576,
   parameter int STABLE_CYCLES  = 1024,
   parameter int STAGE_GAP      = 16,
   parameter int MAX_RETRIES    = 4
) (
   input  logic       clk_74a,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       retry,
   output logic       pll_rst,
   output logic       mem_reset,
   output logic       core_reset,
   output logic       video_reset,
   output logic       ready,
   output logic       fail,
   output logic [2:0] retry_count,
   output logic [7:0] loss_count
);

   // The shared counter only ever needs to reach (largest parameter - 1); one spare bit keeps
   // power-of-two parameters safe.
   localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
   localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW     = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
   localparam logic [2:0]    RETRY_LIMIT = 3'(MAX_RETRIES);

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      REL_MEM   = 3'd3,
      REL_CORE  = 3'd4,
      RUN       = 3'd5,
      FAIL      = 3'd6
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [1:0]    sync_q;
   logic          locked_s;
   logic [2:0]    retry_next;
   logic          retry_inc;
   logic          retry_clr;
   logic          loss_inc;

   assign locked_s   = sync_q[1];
   assign retry_next = retry_count + 3'd1;

   // Bring the asynchronous lock indication into the clk_74a domain.
   always_ff @(posedge clk_74a or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_locked};
      end
   end

   // Next-state decision and bookkeeping strobes for the retry/loss counters.
   always_comb begin
      state_n   = state;
      retry_inc = 1'b0;
      retry_clr = 1'b0;
      loss_inc  = 1'b0;
      case (state)
         PLL_RESET: begin
            if (cnt == RST_LAST) state_n = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_n = STABILIZE;
            end else if (cnt == LOCK_LAST) begin
               retry_inc = 1'b1;
               state_n   = (retry_next == RETRY_LIMIT) ? FAIL : PLL_RESET;
            end
         end
         STABILIZE: begin
            if (!locked_s)               state_n = WAIT_LOCK;
            else if (cnt == STABLE_LAST) state_n = REL_MEM;
         end
         REL_MEM: begin
            if (!locked_s) begin
               loss_inc  = 1'b1;
               retry_clr = 1'b1;
               state_n   = PLL_RESET;
            end else if (cnt == GAP_LAST) begin
               state_n = REL_CORE;
            end
         end
         REL_CORE: begin
            if (!locked_s) begin
               loss_inc  = 1'b1;
               retry_clr = 1'b1;
               state_n   = PLL_RESET;
            end else if (cnt == GAP_LAST) begin
               state_n = RUN;
            end
         end
         RUN: begin
            if (!locked_s) begin
               loss_inc  = 1'b1;
               retry_clr = 1'b1;
               state_n   = PLL_RESET;
            end
         end
         FAIL: begin
            if (retry) begin
               retry_clr = 1'b1;
               state_n   = PLL_RESET;
            end
         end
         default: state_n = PLL_RESET;
      endcase
   end

   // State register and shared cycle counter; the counter restarts on every state change and
   // holds at all-ones in the open-ended states instead of wrapping.
   always_ff @(posedge clk_74a or posedge rst) begin
      if (rst) begin
         state <= PLL_RESET;
         cnt   <= '0;
      end else begin
         state <= state_n;
         if (state_n != state)  cnt <= '0;
         else if (cnt != '1)    cnt <= cnt + 1'b1;
      end
   end

   // Outputs are registered from the next state so each one changes on the edge of entry.
   always_ff @(posedge clk_74a or posedge rst) begin
      if (rst) begin
         pll_rst     <= 1'b1;
         mem_reset   <= 1'b1;
         core_reset  <= 1'b1;
         video_reset <= 1'b1;
         ready       <= 1'b0;
         fail        <= 1'b0;
      end else begin
         pll_rst     <= (state_n == PLL_RESET);
         mem_reset   <= !((state_n == REL_MEM) || (state_n == REL_CORE) || (state_n == RUN));
         core_reset  <= !((state_n == REL_CORE) || (state_n == RUN));
         video_reset <= (state_n != RUN);
         ready       <= (state_n == RUN);
         fail        <= (state_n == FAIL);
      end
   end

   // Retry attempts since last clear, and saturating count of post-release lock losses.
   always_ff @(posedge clk_74a or posedge rst) begin
      if (rst) begin
         retry_count <= 3'd0;
         loss_count  <= 8'd0;
      end else begin
         if (retry_clr)      retry_count <= 3'd0;
         else if (retry_inc) retry_count <= retry_next;
         if (loss_inc && (loss_count != 8'hFF)) loss_count <= loss_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed scoreboard bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       retry;
   logic       pll_rst;
   logic       mem_reset;
   logic       core_reset;
   logic       video_reset;
   logic       ready;
   logic       fail;
   logic [2:0] retry_count;
   logic [7:0] loss_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int base;
   int t0;
   bit mon_en = 0;
   logic [5:0] outs_prev = 6'b111100;

   typedef struct {
      string      tag;
      int         cyc;
      logic [5:0] outs;
   } exp_t;

   exp_t exp_q[$];

   // Output vector order: {pll_rst, mem_reset, core_reset, video_reset, ready, fail}
   localparam logic [5:0] O_RESET = 6'b111100;
   localparam logic [5:0] O_WAIT  = 6'b011100;
   localparam logic [5:0] O_MEM   = 6'b001100;
   localparam logic [5:0] O_CORE  = 6'b000100;
   localparam logic [5:0] O_RUN   = 6'b000010;
   localparam logic [5:0] O_FAIL  = 6'b011101;

   pll_lock_sequencer #(
      .PLL_RST_CYCLES(3),
      .LOCK_TIMEOUT  (64),
      .STABLE_CYCLES (8),
      .STAGE_GAP     (4),
      .MAX_RETRIES   (2)
   ) dut (
      .clk_74a    (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .retry      (retry),
      .pll_rst    (pll_rst),
      .mem_reset  (mem_reset),
      .core_reset (core_reset),
      .video_reset(video_reset),
      .ready      (ready),
      .fail       (fail),
      .retry_count(retry_count),
      .loss_count (loss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int c, input logic [5:0] o);
      exp_t e;
      e.tag  = tag;
      e.cyc  = c;
      e.outs = o;
      exp_q.push_back(e);
   endtask

   // Every output transition must match the next queued expectation in cycle and value.
   always @(negedge clk) begin
      logic [5:0] outs_now;
      exp_t       e;
      outs_now = {pll_rst, mem_reset, core_reset, video_reset, ready, fail};
      if (mon_en && (outs_now !== outs_prev)) begin
         chk("change_expected", longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, "_cyc"}, cyc, e.cyc);
            chk({e.tag, "_outs"}, outs_now, e.outs);
         end
      end
      outs_prev = outs_now;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_to(input int t);
      int guard = 0;
      while (cyc < t && guard < 100000) begin
         tick();
         guard++;
      end
   endtask

   // Asserts rst mid-cycle (retry held high alongside it), checks the asynchronous
   // reset values with no clock edge in between, then releases rst.
   task automatic do_reset(input logic locked_val);
      mon_en = 0;
      tick();
      rst        = 1'b1;
      retry      = 1'b1;
      pll_locked = locked_val;
      #1;
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_domains", {mem_reset, core_reset, video_reset}, 3'b111);
      chk("rst_ready", ready, 0);
      chk("rst_fail", fail, 0);
      chk("rst_retry_count", retry_count, 0);
      chk("rst_loss_count", loss_count, 0);
      chk("rst_queue_drained", exp_q.size(), 0);
      tick();
      retry = 1'b0;
      tick();
      rst    = 1'b0;
      base   = cyc;
      mon_en = 1;
   endtask

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b0;
      retry      = 1'b0;

      // Locked from reset release: full staged release.
      do_reset(1'b1);
      push("s1_pllrst_fall", base + 3,  O_WAIT);
      push("s1_mem_rel",     base + 12, O_MEM);
      push("s1_core_rel",    base + 16, O_CORE);
      push("s1_run",         base + 20, O_RUN);
      wait_to(base + 21);
      chk("s1_ready", ready, 1);
      chk("s1_retry_count", retry_count, 0);

      // Never locked: two reset attempts then FAIL.
      do_reset(1'b0);
      push("s2_pllrst_fall1", base + 3,   O_WAIT);
      push("s2_pllrst_rise2", base + 67,  O_RESET);
      push("s2_pllrst_fall2", base + 70,  O_WAIT);
      push("s2_fail",         base + 134, O_FAIL);
      wait_to(base + 68);
      chk("s2_retry_count_1", retry_count, 1);
      wait_to(base + 136);
      chk("s2_fail", fail, 1);
      chk("s2_retry_count_2", retry_count, 2);
      chk("s2_domains", {mem_reset, core_reset, video_reset}, 3'b111);

      // Lock appearing in FAIL is ignored; a retry pulse restarts the sequence.
      pll_locked = 1'b1;
      wait_to(base + 140);
      t0 = cyc;
      push("s3_retry_pllrst", t0 + 1,  O_RESET);
      push("s3_pllrst_fall",  t0 + 4,  O_WAIT);
      push("s3_mem_rel",      t0 + 13, O_MEM);
      push("s3_core_rel",     t0 + 17, O_CORE);
      push("s3_run",          t0 + 21, O_RUN);
      retry = 1'b1;
      tick();
      retry = 1'b0;
      chk("s3_fail_cleared", fail, 0);
      chk("s3_retry_count", retry_count, 0);
      wait_to(t0 + 22);
      chk("s3_ready", ready, 1);

      // One-cycle lock glitch in STABILIZE restarts the stability window;
      // a retry pulse outside FAIL changes nothing.
      do_reset(1'b1);
      push("s4_pllrst_fall", base + 3,  O_WAIT);
      push("s4_mem_rel",     base + 17, O_MEM);
      push("s4_core_rel",    base + 21, O_CORE);
      push("s4_run",         base + 25, O_RUN);
      wait_to(base + 5);
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_to(base + 10);
      retry = 1'b1;
      tick();
      retry = 1'b0;
      wait_to(base + 26);
      chk("s4_ready", ready, 1);

      // Lock drops in RUN: simultaneous reassertion, loss counting, saturation.
      for (int i = 0; i < 257; i++) begin
         t0 = cyc;
         push("s5_loss",        t0 + 3,  O_RESET);
         push("s5_pllrst_fall", t0 + 6,  O_WAIT);
         push("s5_mem_rel",     t0 + 15, O_MEM);
         push("s5_core_rel",    t0 + 19, O_CORE);
         push("s5_run",         t0 + 23, O_RUN);
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
         wait_to(t0 + 3);
         if (i == 0) begin
            chk("s5_ready_cleared", ready, 0);
            chk("s5_loss_count_1", loss_count, 1);
            chk("s5_retry_count", retry_count, 0);
         end
         if (i == 1)   chk("s5_loss_count_2", loss_count, 2);
         if (i == 254) chk("s5_loss_count_255", loss_count, 255);
         if (i == 256) chk("s5_loss_count_sat", loss_count, 255);
         wait_to(t0 + 24);
      end
      chk("s5_ready_final", ready, 1);

      // Mid-run reset clears the saturated loss count at once.
      do_reset(1'b1);
      mon_en = 0;
      chk("end_queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
